// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC generation, ROM request issue, return queue.
// Ports: clk/rst, rom_ce/rom_addr/rom_data (sync ROM), br_valid/br_target
// (redirect), id_valid/id_ready/id_pc/id_inst (decode handshake), q_count.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [DATA_W-1:0]          rom_data,
    input  logic                       br_valid,
    input  logic [ADDR_W-1:0]          br_target,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [DATA_W-1:0]          id_inst,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              squash;
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [CW:0]       used;
    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target_aligned;

    // Credits cover both held entries and the word still coming back,
    // so a push can never land on a full queue.
    assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue = !rst && !br_valid && (used < (CW+1)'(DEPTH));

    assign rom_ce   = issue;
    assign rom_addr = pc_q;

    assign push = inflight && !squash;
    assign pop  = id_valid && id_ready;

    assign target_aligned = br_target & ~ADDR_W'(3);

    assign id_valid = (count != '0);
    assign id_pc    = mem_pc[rd_ptr];
    assign id_inst  = mem_inst[rd_ptr];
    assign q_count  = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            squash      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else begin
            inflight <= issue;
            squash   <= br_valid;
            if (issue) begin
                inflight_pc <= pc_q;
            end
            if (br_valid) begin
                // Redirect wins over any push/pop this cycle.
                pc_q   <= target_aligned;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) begin
                    pc_q <= pc_q + ADDR_W'(4);
                end
                if (push) begin
                    mem_pc[wr_ptr]   <= inflight_pc;
                    mem_inst[wr_ptr] <= rom_data;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: ROM model plus in-order {pc,inst} scoreboard.
// A second instance with RESET_PC near the top checks address wrap.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  q_count;

    logic        w_rom_ce;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_data = '0;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_inst;
    logic [2:0]  w_q_count;

    logic [31:0] sb[$];
    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
        .br_valid(br_valid), .br_target(br_target),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
    );

    inst_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .rom_ce(w_rom_ce), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .br_valid(1'b0), .br_target(32'h0),
        .id_valid(w_id_valid), .id_ready(1'b1),
        .id_pc(w_id_pc), .id_inst(w_id_inst), .q_count(w_q_count)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        if (rom_ce) rom_data <= rom_word(rom_addr);
        if (w_rom_ce) w_rom_data <= rom_word(w_rom_addr);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        br_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rom_ce !== 1'b0) $display("FAIL reset_rom_ce got=%b want=0", rom_ce);
        else n_pass++;
        n_checks++;
        if (rom_addr !== 32'h0) $display("FAIL reset_rom_addr got=%h want=0", rom_addr);
        else n_pass++;
        n_checks++;
        if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b want=0", id_valid);
        else n_pass++;
        n_checks++;
        if (id_pc !== 32'h0 || id_inst !== 32'h0)
            $display("FAIL reset_id_out got pc=%h inst=%h want 0/0", id_pc, id_inst);
        else n_pass++;
        n_checks++;
        if (q_count !== 3'd0) $display("FAIL reset_q_count got=%0d want=0", q_count);
        else n_pass++;
        n_checks++;
        if (w_rom_addr !== 32'hFFFF_FFF8)
            $display("FAIL reset_wrap_addr got=%h want=fffffff8", w_rom_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int first_v = -1;
        id_ready = 1'b1;
        do_reset();
        sb.delete();
        for (int i = 0; i < 10; i++) sb.push_back(32'(4 * i));
        for (int k = 0; k < 12; k++) begin
            #1;
            n_checks++;
            if (rom_ce !== 1'b1 || rom_addr !== 32'(4 * k))
                $display("FAIL stream_issue got ce=%b addr=%h want ce=1 addr=%h",
                         rom_ce, rom_addr, 32'(4 * k));
            else n_pass++;
            if (id_valid && first_v < 0) first_v = k;
            if (id_valid && id_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL stream_extra got pc=%h want none", id_pc);
                end else begin
                    exp = sb.pop_front();
                    if (id_pc !== exp || id_inst !== rom_word(exp))
                        $display("FAIL stream_data got pc=%h inst=%h want pc=%h inst=%h",
                                 id_pc, id_inst, exp, rom_word(exp));
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (first_v != 2) $display("FAIL stream_latency got=%0d want=2", first_v);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL stream_missing got=%0d left want=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int ce_n = 0;
        int pops = 0;
        id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rom_ce) ce_n++;
            if (k < 9) @(negedge clk);
        end
        n_checks++;
        if (ce_n != 4) $display("FAIL stall_ce_pulses got=%0d want=4", ce_n);
        else n_pass++;
        n_checks++;
        if (q_count !== 3'd4) $display("FAIL stall_q_count got=%0d want=4", q_count);
        else n_pass++;
        n_checks++;
        if (rom_ce !== 1'b0) $display("FAIL stall_rom_ce got=%b want=0", rom_ce);
        else n_pass++;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0)
            $display("FAIL stall_head got v=%b pc=%h want v=1 pc=0", id_valid, id_pc);
        else n_pass++;
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(32'(4 * i));
        id_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL drain_extra got pc=%h want none", id_pc);
                end else begin
                    exp = sb.pop_front();
                    pops++;
                    if (id_pc !== exp || id_inst !== rom_word(exp))
                        $display("FAIL drain_data got pc=%h inst=%h want pc=%h inst=%h",
                                 id_pc, id_inst, exp, rom_word(exp));
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops < 8) $display("FAIL drain_resume got=%0d pops want>=8", pops);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        int pops = 0;
        id_ready = 1'b1;
        do_reset();
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
        for (int k = 0; k < 5; k++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                exp = sb.pop_front();
                if (id_pc !== exp)
                    $display("FAIL pre_br_data got pc=%h want pc=%h", id_pc, exp);
                else n_pass++;
            end
            @(negedge clk);
        end
        br_valid = 1'b1;
        br_target = 32'h100;
        #1;
        n_checks++;
        if (rom_ce !== 1'b0) $display("FAIL br_no_issue got=%b want=0", rom_ce);
        else n_pass++;
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        n_checks++;
        if (q_count !== 3'd0 || id_valid !== 1'b0)
            $display("FAIL br_flush got cnt=%0d v=%b want 0/0", q_count, id_valid);
        else n_pass++;
        n_checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h100)
            $display("FAIL br_refetch got ce=%b addr=%h want 1/100", rom_ce, rom_addr);
        else n_pass++;
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(32'h100 + 32'(4 * i));
        for (int k = 0; k < 8; k++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL br_extra got pc=%h want none", id_pc);
                end else begin
                    exp = sb.pop_front();
                    pops++;
                    if (id_pc !== exp || id_inst !== rom_word(exp))
                        $display("FAIL br_data got pc=%h inst=%h want pc=%h inst=%h",
                                 id_pc, id_inst, exp, rom_word(exp));
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops < 4) $display("FAIL br_stream got=%0d pops want>=4", pops);
        else n_pass++;
    endtask

    task automatic test_redirect2();
        logic [31:0] exp;
        int pops = 0;
        id_ready = 1'b1;
        br_valid = 1'b1;
        br_target = 32'h203;
        @(negedge clk);
        br_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(32'h200 + 32'(4 * i));
        for (int k = 0; k < 6; k++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_inst !== rom_word(exp))
                    $display("FAIL align_data got pc=%h inst=%h want pc=%h inst=%h",
                             id_pc, id_inst, exp, rom_word(exp));
                else n_pass++;
            end
            @(negedge clk);
        end
        br_valid = 1'b1;
        br_target = 32'h40;
        @(negedge clk);
        br_target = 32'h80;
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        n_checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h80)
            $display("FAIL b2b_refetch got ce=%b addr=%h want 1/80", rom_ce, rom_addr);
        else n_pass++;
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back(32'h80 + 32'(4 * i));
        for (int k = 0; k < 8; k++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_extra got pc=%h want none", id_pc);
                end else begin
                    exp = sb.pop_front();
                    pops++;
                    if (id_pc !== exp || id_inst !== rom_word(exp))
                        $display("FAIL b2b_data got pc=%h inst=%h want pc=%h inst=%h",
                                 id_pc, id_inst, exp, rom_word(exp));
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops < 4) $display("FAIL b2b_stream got=%0d pops want>=4", pops);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] wsb[$];
        logic [31:0] exp;
        int pops = 0;
        do_reset();
        wsb.push_back(32'hFFFF_FFF8);
        wsb.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 6; i++) wsb.push_back(32'(4 * i));
        for (int k = 0; k < 8; k++) begin
            #1;
            if (w_id_valid) begin
                n_checks++;
                exp = wsb.pop_front();
                pops++;
                if (w_id_pc !== exp || w_id_inst !== rom_word(exp))
                    $display("FAIL wrap_data got pc=%h inst=%h want pc=%h inst=%h",
                             w_id_pc, w_id_inst, exp, rom_word(exp));
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pops != 6) $display("FAIL wrap_count got=%0d pops want=6", pops);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp;
        int k = 0;
        bit found = 0;
        id_ready = 1'b0;
        do_reset();
        while (!found && k < 10) begin
            #1;
            if (q_count === 3'd3) found = 1;
            else @(negedge clk);
            k++;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL midrst_fill got cnt=%0d want=3 within 10 cycles", q_count);
        end else begin
            rst = 1'b1;
            #1;
            if (id_valid !== 1'b0 || rom_ce !== 1'b0 || q_count !== 3'd0)
                $display("FAIL midrst_clear got v=%b ce=%b cnt=%0d want 0/0/0",
                         id_valid, rom_ce, q_count);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        id_ready = 1'b1;
        #1;
        n_checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0)
            $display("FAIL midrst_restart got ce=%b addr=%h want 1/0", rom_ce, rom_addr);
        else n_pass++;
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < 6; i++) sb.push_back(32'(4 * i));
        for (int j = 0; j < 6; j++) begin
            #1;
            if (id_valid && id_ready) begin
                n_checks++;
                exp = sb.pop_front();
                if (id_pc !== exp || id_inst !== rom_word(exp))
                    $display("FAIL midrst_data got pc=%h inst=%h want pc=%h inst=%h",
                             id_pc, id_inst, exp, rom_word(exp));
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect2();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
